// File: rtl/instr_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_memory                                                  |
// | Purpose  : Instruction-side responder for a Harvard MIPS CPU. Preloaded  |
// |            over a valid/ready word stream, then answers combinational    |
// |            fetches, tracks LOAD/RUN/HALTED/TIMEOUT, counts fetches and   |
// |            flags bad fetch addresses.                                    |
// | Options  : `define IMEM_WATCHDOG_EN adds a RUN-state watchdog that moves |
// |            to the TIMEOUT state after TIMEOUT enabled cycles.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module instr_memory #(
  parameter int          DEPTH        = 64,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        mem_ready,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        halted,
  output logic        addr_fault,
  output logic        timeout,
  output logic [15:0] fetch_count
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Reject unsupported configurations at elaboration time.
  generate
    if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
      $error("instr_memory: DEPTH must be a power of 2 in 2..1024 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t      state;
  logic [AW-1:0] wptr;
  logic [31:0] mem [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] index;
  logic          in_window;
  logic          load_fire;
  logic          load_done;
  logic          wd_expire;
  logic          timeout_flag;

  // Window decode: a wrapped subtract makes addresses below the vector land far out of range.
  assign offset    = instr_address - RESET_VECTOR;
  assign index     = offset[AW+1:2];
  assign in_window = (offset[1:0] == 2'b00) && (offset[31:AW+2] == '0);

  // A load beat is only meaningful while the stream is still being accepted.
  assign load_fire = (state == ST_LOAD) && load_valid;
  assign load_done = load_last || (wptr == LAST_IDX);

`ifdef IMEM_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  // Watchdog: counts enabled RUN edges; never needs to wrap because RUN ends on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if ((state == ST_RUN) && clk_enable) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Expiry on the edge that brings the count to TIMEOUT; a halt fetch on that edge takes priority.
  assign wd_expire = (state == ST_RUN) && clk_enable && (instr_address != 32'd0) &&
                     (wd_cnt == WDW'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  assign timeout = timeout_flag;

  // Storage: cleared on reset, written only by accepted load beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (load_fire) begin
      mem[wptr] <= load_data;
    end
  end

  // Fetch data: only RUN-state in-window fetches see storage; everything else reads as NOP.
  always_comb begin
    instr_readdata = 32'd0;
    if ((state == ST_RUN) && in_window) begin
      instr_readdata = mem[index];
    end
  end

  // Run-state machine with registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_LOAD;
      wptr         <= '0;
      load_ready   <= 1'b1;
      mem_ready    <= 1'b0;
      halted       <= 1'b0;
      addr_fault   <= 1'b0;
      timeout_flag <= 1'b0;
      fetch_count  <= 16'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            wptr <= wptr + 1'b1;
            // Either the explicit last beat or a full memory ends the load.
            if (load_done) begin
              state      <= ST_RUN;
              load_ready <= 1'b0;
              mem_ready  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (clk_enable) begin
            if (instr_address == 32'd0) begin
              // Fetch of address 0 is the CPU's end-of-program marker.
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
              end
              if (!in_window) begin
                addr_fault <= 1'b1;
              end
              if (wd_expire) begin
                state        <= ST_TIMEOUT;
                timeout_flag <= 1'b1;
              end
            end
          end
        end
        default: begin
          // HALTED and TIMEOUT hold everything until reset.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_memory                                               |
// | Purpose  : Directed self-checking bench for instr_memory with a queue    |
// |            scoreboard of expected values.                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instr_memory;

  localparam int          DEPTH = 64;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam int          TO    = 16;
`ifdef IMEM_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        mem_ready;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        halted;
  logic        addr_fault;
  logic        timeout;
  logic [15:0] fetch_count;

  instr_memory #(
    .DEPTH(DEPTH),
    .RESET_VECTOR(RV),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .load_last(load_last),
    .mem_ready(mem_ready),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .halted(halted),
    .addr_fault(addr_fault),
    .timeout(timeout),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic apply_reset();
    clk_enable    = 1'b0;
    load_valid    = 1'b0;
    load_last     = 1'b0;
    instr_address = RV;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [31:0] addr);
    instr_address = addr;
    clk_enable    = 1'b1;
    tick();
    clk_enable    = 1'b0;
  endtask

  // Stimulus: linear directed steps.
  initial begin
    reset         = 1'b0;
    clk_enable    = 1'b0;
    load_valid    = 1'b0;
    load_data     = 32'd0;
    load_last     = 1'b0;
    instr_address = RV;
    #12;

    // Reset state
    push("rst_load_ready", 32'd1);  chk({31'd0, load_ready});
    push("rst_mem_ready", 32'd0);   chk({31'd0, mem_ready});
    push("rst_halted", 32'd0);      chk({31'd0, halted});
    push("rst_addr_fault", 32'd0);  chk({31'd0, addr_fault});
    push("rst_timeout", 32'd0);     chk({31'd0, timeout});
    push("rst_fetch_count", 32'd0); chk({16'd0, fetch_count});
    push("rst_readdata", 32'd0);    chk(instr_readdata);
    reset = 1'b1;
    tick();

    // Five-word program load
    instr_address = RV;
    push("load_readdata_zero", 32'd0); #1; chk(instr_readdata);
    load_beat(32'h24844AAA, 1'b0);
    load_beat(32'h00042400, 1'b0);
    load_beat(32'h24846006, 1'b0);
    load_beat(32'h00000008, 1'b0);
    load_beat(32'h24000000, 1'b1);
    push("run_mem_ready", 32'd1);  chk({31'd0, mem_ready});
    push("run_load_ready", 32'd0); chk({31'd0, load_ready});
    instr_address = RV + 32'd4;
    push("rd_bfc00004", 32'h00042400); #1; chk(instr_readdata);
    instr_address = RV + 32'd16;
    push("rd_bfc00010", 32'h24000000); #1; chk(instr_readdata);
    instr_address = RV + 32'd20;
    push("rd_unwritten", 32'd0); #1; chk(instr_readdata);
    push("no_enable_count", 32'd0); chk({16'd0, fetch_count});

    // Sequential fetches then halt
    instr_address = RV;
    push("rd_bfc00000", 32'h24844AAA); #1; chk(instr_readdata);
    fetch(RV);
    fetch(RV + 32'd4);
    fetch(RV + 32'd8);
    fetch(RV + 32'd12);
    push("fetch_count_4", 32'd4); chk({16'd0, fetch_count});
    push("pre_halt", 32'd0);      chk({31'd0, halted});
    fetch(32'd0);
    push("halted_set", 32'd1);       chk({31'd0, halted});
    push("halt_count_4", 32'd4);     chk({16'd0, fetch_count});
    instr_address = RV + 32'd4;
    push("halt_readdata", 32'd0);    #1; chk(instr_readdata);
    push("halt_mem_ready", 32'd1);   chk({31'd0, mem_ready});
    fetch(RV + 32'd8);
    push("halt_frozen_count", 32'd4); chk({16'd0, fetch_count});
    push("halt_no_fault", 32'd0);     chk({31'd0, addr_fault});

    // Bad fetch addresses in RUN
    apply_reset();
    load_beat(32'h11111111, 1'b1);
    instr_address = RV + 32'd2;
    push("misaligned_rd", 32'd0); #1; chk(instr_readdata);
    fetch(RV + 32'd2);
    push("fault_misaligned", 32'd1); chk({31'd0, addr_fault});
    push("fault_count_1", 32'd1);    chk({16'd0, fetch_count});
    instr_address = RV + 32'h100;
    push("oow_rd", 32'd0); #1; chk(instr_readdata);
    fetch(RV + 32'h100);
    push("fault_count_2", 32'd2); chk({16'd0, fetch_count});
    instr_address = RV - 32'd4;
    push("below_vector_rd", 32'd0); #1; chk(instr_readdata);
    instr_address = RV;
    push("still_run_rd", 32'h11111111); #1; chk(instr_readdata);
    instr_address = 32'd0;
    clk_enable = 1'b0;
    tick();
    push("disabled_no_halt", 32'd0);  chk({31'd0, halted});
    push("disabled_count_2", 32'd2);  chk({16'd0, fetch_count});

    // Full-depth stream without load_last
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load_beat(32'hA0000000 + 32'(i), 1'b0);
    end
    push("full_mem_ready", 32'd1);  chk({31'd0, mem_ready});
    push("full_load_ready", 32'd0); chk({31'd0, load_ready});
    load_beat(32'hDEADBEEF, 1'b0);
    instr_address = RV;
    push("full_mem0", 32'hA0000000); #1; chk(instr_readdata);
    instr_address = RV + 32'(4 * (DEPTH - 1));
    push("full_mem_last", 32'hA0000000 + 32'(DEPTH - 1)); #1; chk(instr_readdata);

    // Watchdog: enabled edges only, loop within window
    apply_reset();
    load_beat(32'h22222222, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      fetch(RV);
      tick();
    end
    push("wd_not_yet", 32'd0); chk({31'd0, timeout});
    fetch(RV);
    push("wd_timeout", {31'd0, WD}); chk({31'd0, timeout});
    push("wd_count", 32'(TO)); chk({16'd0, fetch_count});
    instr_address = RV;
    push("wd_readdata", WD ? 32'd0 : 32'h22222222); #1; chk(instr_readdata);

    // Halt on the expiry edge wins over the watchdog
    apply_reset();
    load_beat(32'h33333333, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      fetch(RV + 32'd4);
    end
    fetch(32'd0);
    push("tie_halted", 32'd1);  chk({31'd0, halted});
    push("tie_timeout", 32'd0); chk({31'd0, timeout});

    // Reset mid-load clears everything
    apply_reset();
    load_beat(32'h44444444, 1'b0);
    load_beat(32'h55555555, 1'b0);
    load_beat(32'h66666666, 1'b0);
    reset = 1'b0;
    #2;
    push("midrst_load_ready", 32'd1); chk({31'd0, load_ready});
    push("midrst_mem_ready", 32'd0);  chk({31'd0, mem_ready});
    push("midrst_count", 32'd0);      chk({16'd0, fetch_count});
    reset = 1'b1;
    tick();
    load_beat(32'd0, 1'b1);
    instr_address = RV;
    push("reload_mem0", 32'd0); #1; chk(instr_readdata);
    instr_address = RV + 32'd4;
    push("reload_mem1_cleared", 32'd0); #1; chk(instr_readdata);
    push("reload_mem_ready", 32'd1); chk({31'd0, mem_ready});

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
